seg_display_scheduler: RTL and testbench

Shares the board's single 4-digit hex seven-segment display between several 16-bit value producers, e.g. ALU result, PC, register-file probe and debug word. Each producer raises a request. The block grants sources round-robin and latches the granted value. It then holds that value on the display for a minimum dwell time before serving the next request. Its disp_value output drives the result input of the seg7 multiplexing driver.

---
 rtl/seg_display_scheduler_pkg.sv | 17 +
 rtl/seg_display_scheduler_rr_arbiter.sv | 43 ++++
 rtl/seg_display_scheduler.sv | 133 +++++++++++++
 tb/tb_seg_display_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scheduler_pkg.sv
// rtl/seg_display_scheduler_pkg.sv - shared constants and state type for the display scheduler
//
// Purpose: common definitions imported by seg_display_scheduler and rr_arbiter.
//   SEG_DATA_W           width of one displayed value (4 hex digits)
//   DEFAULT_DWELL_CYCLES dwell length giving 1 s at 100 MHz
//   state_t              scheduler states
package seg_disp_pkg;

  localparam int SEG_DATA_W           = 16;
  localparam int DEFAULT_DWELL_CYCLES = 100_000_000;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/seg_display_scheduler_rr_arbiter.sv
// rtl/seg_display_scheduler_rr_arbiter.sv - combinational round-robin pick
//
// Purpose: picks the first requesting index strictly after ptr, wrapping.
// Ports:
//   req          per-source request vector
//   ptr          index of the most recently served source
//   grant_valid  at least one request present
//   grant_idx    picked index (0 when grant_valid=0)
//   grant        one-hot form of grant_idx (all zero when grant_valid=0)
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [SRC_W-1:0]   grant_idx,
  output logic [NUM_SRC-1:0] grant
);

  always_comb begin
    int               idx;
    logic [SRC_W-1:0] idx_w;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    idx         = 0;
    idx_w       = '0;
    // Scan from the farthest position back to the nearest; the last hit wins,
    // so the nearest requester after ptr ends up selected.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = SRC_W'(idx);
      if (req[idx_w]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_w;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - round-robin sharing of one 4-digit hex display
//
// Purpose: grants requesting sources in round-robin order, latches the granted
// value and holds it for at least DWELL_CYCLES before serving the next one.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req          per-source level request, held until ack
//   data         per-source values, source i at [16*i+15:16*i]
//   freeze       stops the dwell timer and blocks grants
//   ack          one-hot single-cycle capture pulse
//   disp_value   value shown on the display
//   disp_src     source owning disp_value
//   disp_valid   set on the first grant after reset
//   busy         high while dwelling
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int SRC_W        = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            req,
  input  logic [SEG_DATA_W*NUM_SRC-1:0] data,
  input  logic                          freeze,
  output logic [NUM_SRC-1:0]            ack,
  output logic [SEG_DATA_W-1:0]         disp_value,
  output logic [SRC_W-1:0]              disp_src,
  output logic                          disp_valid,
  output logic                          busy
);

  localparam int TMR_W = $clog2(DWELL_CYCLES);

  state_t                  state, state_nxt;
  logic [TMR_W-1:0]        timer, timer_nxt;
  logic [SRC_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [NUM_SRC-1:0]      ack_nxt;
  logic [SEG_DATA_W-1:0]   value_nxt;
  logic [SRC_W-1:0]        src_nxt;
  logic                    valid_nxt;
  logic                    busy_nxt;
  logic                    do_grant;

  logic                    grant_valid;
  logic [SRC_W-1:0]        grant_idx;
  logic [NUM_SRC-1:0]      grant;
  logic [SEG_DATA_W-1:0]   src_data [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i] = data[i*SEG_DATA_W +: SEG_DATA_W];
    end
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant       (grant)
  );

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    rr_ptr_nxt = rr_ptr;
    ack_nxt    = '0;
    value_nxt  = disp_value;
    src_nxt    = disp_src;
    valid_nxt  = disp_valid;
    do_grant   = 1'b0;

    case (state)
      IDLE: begin
        if (!freeze && grant_valid) do_grant = 1'b1;
      end
      DWELL: begin
        if (!freeze) begin
          if (timer != '0) begin
            timer_nxt = timer - 1'b1;
          end else if (grant_valid) begin
            // Grant on the expiry edge so consecutive displays are exactly
            // DWELL_CYCLES apart.
            do_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_grant) begin
      value_nxt  = src_data[grant_idx];
      src_nxt    = grant_idx;
      valid_nxt  = 1'b1;
      ack_nxt    = grant;
      rr_ptr_nxt = grant_idx;
      timer_nxt  = TMR_W'(DWELL_CYCLES - 1);
      state_nxt  = DWELL;
    end

    busy_nxt = (state_nxt == DWELL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      rr_ptr     <= SRC_W'(NUM_SRC - 1);
      ack        <= '0;
      disp_value <= '0;
      disp_src   <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      rr_ptr     <= rr_ptr_nxt;
      ack        <= ack_nxt;
      disp_value <= value_nxt;
      disp_src   <= src_nxt;
      disp_valid <= valid_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - self-checking bench for seg_display_scheduler
module tb_seg_display_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic [N-1:0]  req;
  logic [16*N-1:0] data;
  logic [N-1:0]  ack;
  logic [15:0]   disp_value;
  logic [1:0]    disp_src;
  logic          disp_valid;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seg_display_scheduler #(
    .NUM_SRC      (N),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .freeze     (freeze),
    .ack        (ack),
    .disp_value (disp_value),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  // Reference: a source may be granted once it has seen DW unfrozen edges since
  // the previous grant (the grant edge itself not counted). m_u counts those
  // edges, saturating at DW; busy means the count is still below DW.
  int          m_u;
  int          m_last;
  logic [N-1:0] m_ack;
  logic [15:0] m_val;
  logic [1:0]  m_src;
  logic        m_valid;
  logic        m_busy;

  task automatic model_step();
    int  pick;
    bit  found;
    if (rst) begin
      m_u = DW; m_last = N - 1; m_ack = '0; m_val = '0;
      m_src = '0; m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      m_ack = '0;
      if (!freeze && m_u < DW) m_u = m_u + 1;
      if (!freeze && req != '0 && m_u >= DW) begin
        found = 0; pick = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req[(m_last + k) % N]) begin
            found = 1; pick = (m_last + k) % N;
          end
        end
        m_val   = data[pick*16 +: 16];
        m_src   = 2'(pick);
        m_valid = 1'b1;
        m_ack   = N'(1) << pick;
        m_last  = pick;
        m_u     = 0;
      end
      m_busy = (m_u < DW);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; freeze = 1'b0; data = '0;
    cycle(); cycle();
    rst = 1'b0;
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    tests_run++; if (disp_value !== 16'h0000) begin tests_failed++; $display("FAIL reset_value: got %h expected 0000", disp_value); end
    tests_run++; if (disp_src !== 2'd0) begin tests_failed++; $display("FAIL reset_src: got %0d expected 0", disp_src); end
    tests_run++; if (disp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", disp_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    data[47:32] = 16'hBEEF;
    req = 4'b0100;
    cycle();
    req = '0;
    tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL single_ack: got %b expected 0100", ack); end
    tests_run++; if (disp_value !== 16'hBEEF) begin tests_failed++; $display("FAIL single_value: got %h expected beef", disp_value); end
    tests_run++; if (disp_src !== 2'd2) begin tests_failed++; $display("FAIL single_src: got %0d expected 2", disp_src); end
    tests_run++; if (disp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", disp_valid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy0: got %b expected 1", busy); end
    for (int k = 1; k < DW; k++) begin
      cycle();
      tests_run++; if (busy !== 1'b1 || ack !== 4'b0000) begin tests_failed++; $display("FAIL single_dwell c%0d: busy %b ack %b expected busy 1 ack 0000", k, busy, ack); end
    end
    cycle();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    tests_run++; if (disp_value !== 16'hBEEF) begin tests_failed++; $display("FAIL single_hold: got %h expected beef", disp_value); end
  endtask

  task automatic test_round_robin();
    logic [15:0] ev;
    logic [1:0]  es;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < N; i++) data[i*16 +: 16] = 16'h1110 + 16'(i);
    req = 4'b1111;
    cycle();
    for (int g = 0; g <= 4; g++) begin
      es = 2'(g % 4);
      ev = 16'h1110 + 16'(g % 4);
      tests_run++; if (ack !== (4'b0001 << es)) begin tests_failed++; $display("FAIL rr_ack g%0d: got %b expected source %0d", g, ack, es); end
      tests_run++; if (disp_value !== ev || disp_src !== es) begin tests_failed++; $display("FAIL rr_value g%0d: got %h/%0d expected %h/%0d", g, disp_value, disp_src, ev, es); end
      if (g != 4) begin
        for (int k = 1; k <= DW; k++) begin
          cycle();
          if (k < DW) begin
            tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL rr_gap g%0d c%0d: got %b expected 0000", g, k, ack); end
          end
        end
      end
    end
    req = '0;
    repeat (DW) cycle();
  endtask

  task automatic test_fairness();
    req = 4'b0010;
    cycle();
    tests_run++; if (ack !== 4'b0010) begin tests_failed++; $display("FAIL fair_first: got %b expected 0010", ack); end
    repeat (3) cycle();
    req = 4'b1010;
    repeat (DW - 3) cycle();
    tests_run++; if (ack !== 4'b1000) begin tests_failed++; $display("FAIL fair_src3: got %b expected 1000", ack); end
    req = 4'b0010;
    repeat (DW) cycle();
    tests_run++; if (ack !== 4'b0010) begin tests_failed++; $display("FAIL fair_src1_again: got %b expected 0010", ack); end
    req = '0;
    repeat (DW) cycle();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL fair_idle: got %b expected 0", busy); end
  endtask

  task automatic test_freeze();
    req = 4'b0001;
    cycle();
    tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL frz_grant: got %b expected 0001", ack); end
    repeat (2) cycle();
    freeze = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests_run++; if (ack !== 4'b0000 || busy !== 1'b1) begin tests_failed++; $display("FAIL frz_hold c%0d: ack %b busy %b expected 0000/1", k, ack, busy); end
    end
    freeze = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL frz_resume c%0d: got %b expected 0000", k, ack); end
    end
    cycle();
    tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL frz_delayed_ack: got %b expected 0001", ack); end
    req = '0;
    repeat (DW) cycle();
  endtask

  task automatic test_reset_mid_dwell();
    req = 4'b0100;
    cycle();
    tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL rstmid_grant: got %b expected 0100", ack); end
    req = '0;
    repeat (4) cycle();
    rst = 1'b1; req = 4'b1010;
    cycle();
    tests_run++; if (ack !== 4'b0000 || disp_value !== 16'h0000 || disp_src !== 2'd0 || disp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_outputs: ack %b val %h src %0d valid %b busy %b expected all zero", ack, disp_value, disp_src, disp_valid, busy);
    end
    rst = 1'b0;
    cycle();
    tests_run++; if (ack !== 4'b0010 || disp_src !== 2'd1 || disp_value !== 16'h1111) begin tests_failed++; $display("FAIL rstmid_lowest: ack %b src %0d val %h expected 0010/1/1111", ack, disp_src, disp_value); end
    req = '0;
    repeat (DW) cycle();
  endtask

  task automatic test_dropped_req();
    logic [15:0] v0;
    v0 = data[15:0];
    req = 4'b0001;
    cycle();
    tests_run++; if (ack !== 4'b0001 || disp_value !== v0) begin tests_failed++; $display("FAIL drop_grant: ack %b val %h expected 0001/%h", ack, disp_value, v0); end
    req = '0;
    repeat (2) cycle();
    req = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k == 1) req = '0;
      tests_run++; if (ack[1] !== 1'b0) begin tests_failed++; $display("FAIL drop_no_ack c%0d: got ack %b expected bit1 0", k, ack); end
    end
    tests_run++; if (busy !== 1'b0 || disp_value !== v0 || disp_src !== 2'd0) begin tests_failed++; $display("FAIL drop_idle: busy %b val %h src %0d expected 0/%h/0", busy, disp_value, disp_src, v0); end
  endtask

  task automatic test_random();
    logic f_edge;
    rst = 1'b1; req = '0; freeze = 1'b0;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      else if (ack != '0) req = req & ~ack;
      data = {$urandom, $urandom};
      f_edge = freeze;
      cycle();
      tests_run++; if (ack !== m_ack) begin tests_failed++; $display("FAIL rnd_ack c%0d: got %b expected %b", c, ack, m_ack); end
      tests_run++; if (disp_value !== m_val) begin tests_failed++; $display("FAIL rnd_value c%0d: got %h expected %h", c, disp_value, m_val); end
      tests_run++; if (disp_src !== m_src) begin tests_failed++; $display("FAIL rnd_src c%0d: got %0d expected %0d", c, disp_src, m_src); end
      tests_run++; if (disp_valid !== m_valid) begin tests_failed++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, disp_valid, m_valid); end
      tests_run++; if (busy !== m_busy) begin tests_failed++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, m_busy); end
      tests_run++; if ($countones(ack) > 1 || (f_edge && ack !== '0)) begin tests_failed++; $display("FAIL rnd_ack_rule c%0d: got %b freeze %b expected at most one bit, none when frozen", c, ack, f_edge); end
    end
    rst = 1'b0; freeze = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; freeze = 1'b0; data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_freeze();
    test_reset_mid_dwell();
    test_dropped_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
